fetch_prefetch_queue: RTL and testbench

Parametrised instruction-fetch stage with a prefetch buffer. It drives a synchronous instruction ROM and buffers up to DEPTH fetched words. Each word is tagged with its PC and handed to decode over a valid/ready handshake. A redirect input (branch/jump) flushes the buffer and discards any in-flight ROM response. The block sits between the instruction ROM and the decode stage.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_prefetch_queue.sv | 85 ++++++++
 tb/tb_fetch_prefetch_queue.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults for the instruction-fetch slice: widths, reset PC and the
// layout of a prefetch buffer entry.
package fetch_pkg;

    localparam int          FETCH_DATA_W   = 8;
    localparam int          FETCH_ADDR_W   = 8;
    localparam int unsigned FETCH_RESET_PC = 0;
    localparam int          FETCH_ENTRY_W  = FETCH_ADDR_W + FETCH_DATA_W;

    // Buffer entry: PC in the upper bits, instruction word in the lower bits.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a single-cycle flush, used as the fetch prefetch buffer.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = FETCH_ENTRY_W,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Reset and flush take priority over any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (arst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch stage: issues ROM reads against buffer credit, tags each
// returned word with its PC and presents it to decode over valid/ready.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int          DATA_W   = FETCH_DATA_W,
    parameter int          ADDR_W   = FETCH_ADDR_W,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = FETCH_RESET_PC,
    localparam int         CNT_W    = $clog2(DEPTH) + 1,
    localparam int         ENTRY_W  = ADDR_W + DATA_W
) (
    input  logic              clk,
    input  logic              arst,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  occupancy
);

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic [CNT_W:0]     credit_used;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;

    // A read is only issued when a slot is guaranteed for its response, so
    // the push a cycle later never meets a full buffer.
    assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign rom_en      = !arst && !redirect_valid && !full
                         && (credit_used < (CNT_W+1)'(DEPTH));
    assign rom_addr    = fetch_pc;

    // A redirect kills the response arriving in its own cycle.
    assign push = inflight && !redirect_valid;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (arst) begin
            fetch_pc    <= ADDR_W'(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= rom_en;
            if (rom_en) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 1'b1;
            end
            if (redirect_valid) fetch_pc <= redirect_pc;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arst      (arst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({inflight_pc, rom_data}),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign out_valid = !empty;
    assign out_pc    = empty ? '0 : head[ENTRY_W-1:DATA_W];
    assign out_inst  = empty ? '0 : head[DATA_W-1:0];
    assign occupancy = count;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: cycle table for reset/backpressure, PC-order
// scoreboard on every decode transfer, and hand sequences for reset/redirect.
module tb_fetch_prefetch_queue;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       arst, arst1;
    logic       rom_en0, rom_en1;
    logic [7:0] rom_addr0, rom_addr1;
    logic [7:0] rom_data0, rom_data1;
    logic       out_valid0, out_valid1;
    logic       out_ready0, out_ready1;
    logic [7:0] out_inst0, out_inst1;
    logic [7:0] out_pc0, out_pc1;
    logic       redirect_valid, redirect_valid1;
    logic [7:0] redirect_pc, redirect_pc1;
    logic [2:0] occupancy0, occupancy1;

    fetch_prefetch_queue #(.DATA_W(8), .ADDR_W(8), .DEPTH(4), .RESET_PC(0)) dut0 (
        .clk(clk), .arst(arst), .rom_en(rom_en0), .rom_addr(rom_addr0),
        .rom_data(rom_data0), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_inst(out_inst0), .out_pc(out_pc0), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .occupancy(occupancy0)
    );

    fetch_prefetch_queue #(.DATA_W(8), .ADDR_W(8), .DEPTH(4), .RESET_PC(32'hFD)) dut1 (
        .clk(clk), .arst(arst1), .rom_en(rom_en1), .rom_addr(rom_addr1),
        .rom_data(rom_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_inst(out_inst1), .out_pc(out_pc1), .redirect_valid(redirect_valid1),
        .redirect_pc(redirect_pc1), .occupancy(occupancy1)
    );

    // Synchronous ROM models: mem[a] = a ^ 0x5A, one cycle read latency.
    always @(posedge clk) if (rom_en0) rom_data0 <= rom_addr0 ^ 8'h5A;
    always @(posedge clk) if (rom_en1) rom_data1 <= rom_addr1 ^ 8'h5A;

    int         errors = 0;
    int         checks = 0;
    int         n1     = 0;
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];

    typedef struct {
        logic       arst;
        logic       rdy;
        logic       en;
        logic [7:0] addr;
        logic       ov;
        logic [7:0] pc;
        logic [2:0] occ;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_restart0(input logic [7:0] start);
        logic [7:0] p;
        p = start;
        exp0.delete();
        for (int i = 0; i < 64; i++) begin
            exp0.push_back(p);
            p = p + 8'd1;
        end
    endtask

    // Compare every decode transfer against the expected PC order.
    task automatic sb_check();
        logic [7:0] e;
        if (out_valid0 === 1'b1 && out_ready0 === 1'b1) begin
            if (exp0.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb0_underflow: got pc 0x%0h expected no transfer at %0t", out_pc0, $time);
            end else begin
                e = exp0.pop_front();
                chk("sb0_pc", out_pc0, e);
                chk("sb0_inst", out_inst0, e ^ 8'h5A);
            end
        end
        if (out_valid1 === 1'b1 && out_ready1 === 1'b1) begin
            n1++;
            if (exp1.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb1_underflow: got pc 0x%0h expected no transfer at %0t", out_pc1, $time);
            end else begin
                e = exp1.pop_front();
                chk("sb1_pc", out_pc1, e);
                chk("sb1_inst", out_inst1, e ^ 8'h5A);
            end
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        sb_check();
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        at_neg();
        next();
    endtask

    task automatic do_reset();
        out_ready0 = 1'b0;
        arst = 1'b1;
        step();
        step();
        arst = 1'b0;
        sb_restart0(8'h00);
    endtask

    initial begin
        logic [7:0] p;
        arst = 1'b1; arst1 = 1'b1;
        out_ready0 = 1'b0; out_ready1 = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 8'h00;
        redirect_valid1 = 1'b0; redirect_pc1 = 8'h00;

        //            arst  rdy   en    addr   ov    pc     occ
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 3'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 8'h00, 3'd1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 8'h00, 3'd2};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h04, 1'b1, 8'h00, 3'd3};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h04, 1'b1, 8'h00, 3'd4};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h04, 1'b1, 8'h00, 3'd4};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h04, 1'b1, 8'h00, 3'd4};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h04, 1'b1, 8'h01, 3'd3};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 8'h02, 3'd2};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 8'h06, 1'b1, 8'h03, 3'd2};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 8'h04, 3'd2};

        sb_restart0(8'h00);
        p = 8'hFD;
        for (int i = 0; i < 200; i++) begin
            exp1.push_back(p);
            p = p + 8'd1;
        end

        step();
        step();
        arst1 = 1'b0;
        out_ready1 = 1'b1;

        // Reset, latency, backpressure saturation and drain.
        for (int i = 0; i < 13; i++) begin
            arst = tbl[i].arst;
            out_ready0 = tbl[i].rdy;
            at_neg();
            chk("tbl_rom_en", {7'b0, rom_en0}, {7'b0, tbl[i].en});
            chk("tbl_rom_addr", rom_addr0, tbl[i].addr);
            chk("tbl_out_valid", {7'b0, out_valid0}, {7'b0, tbl[i].ov});
            chk("tbl_occupancy", {5'b0, occupancy0}, {5'b0, tbl[i].occ});
            if (tbl[i].ov) chk("tbl_out_pc", out_pc0, tbl[i].pc);
            next();
        end

        // Full throughput: no bubbles while out_ready stays high.
        for (int i = 0; i < 8; i++) begin
            at_neg();
            chk("stream_out_valid", {7'b0, out_valid0}, 8'd1);
            next();
        end

        // One-cycle reset pulse with 3 buffered entries and a read in flight.
        do_reset();
        for (int i = 0; i < 4; i++) step();
        arst = 1'b1;
        at_neg();
        chk("pulse_pre_occ", {5'b0, occupancy0}, 8'd3);
        chk("pulse_rom_en", {7'b0, rom_en0}, 8'd0);
        next();
        arst = 1'b0;
        sb_restart0(8'h00);
        at_neg();
        chk("pulse_occ", {5'b0, occupancy0}, 8'd0);
        chk("pulse_out_valid", {7'b0, out_valid0}, 8'd0);
        chk("pulse_rom_en1", {7'b0, rom_en0}, 8'd1);
        chk("pulse_rom_addr", rom_addr0, 8'h00);
        next();
        at_neg();
        chk("pulse_occ2", {5'b0, occupancy0}, 8'd0);
        chk("pulse_out_valid2", {7'b0, out_valid0}, 8'd0);
        next();
        at_neg();
        chk("pulse_out_valid3", {7'b0, out_valid0}, 8'd1);
        chk("pulse_out_pc", out_pc0, 8'h00);
        chk("pulse_out_inst", out_inst0, 8'h5A);
        chk("pulse_occ3", {5'b0, occupancy0}, 8'd1);
        next();
        out_ready0 = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Redirect while the response for 0x07 is in flight.
        do_reset();
        out_ready0 = 1'b1;
        for (int i = 0; i < 8; i++) step();
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        at_neg();
        chk("redir_rom_en", {7'b0, rom_en0}, 8'd0);
        chk("redir_pre_occ", {5'b0, occupancy0}, 8'd1);
        sb_restart0(8'h40);
        next();
        redirect_valid = 1'b0;
        at_neg();
        chk("redir_n1_rom_en", {7'b0, rom_en0}, 8'd1);
        chk("redir_n1_rom_addr", rom_addr0, 8'h40);
        chk("redir_n1_occ", {5'b0, occupancy0}, 8'd0);
        chk("redir_n1_out_valid", {7'b0, out_valid0}, 8'd0);
        next();
        step();
        at_neg();
        chk("redir_n3_out_valid", {7'b0, out_valid0}, 8'd1);
        chk("redir_n3_out_pc", out_pc0, 8'h40);
        next();

        // Back-to-back redirects: last wins, no issue while redirecting.
        redirect_valid = 1'b1; redirect_pc = 8'h20;
        at_neg();
        chk("b2b_a_rom_en", {7'b0, rom_en0}, 8'd0);
        sb_restart0(8'h20);
        next();
        redirect_pc = 8'h10;
        at_neg();
        chk("b2b_b_rom_en", {7'b0, rom_en0}, 8'd0);
        chk("b2b_b_out_valid", {7'b0, out_valid0}, 8'd0);
        sb_restart0(8'h10);
        next();
        redirect_valid = 1'b0;
        at_neg();
        chk("b2b_rom_en", {7'b0, rom_en0}, 8'd1);
        chk("b2b_rom_addr", rom_addr0, 8'h10);
        next();
        step();

        // Redirect in the same cycle as the transfer of 0x10.
        redirect_valid = 1'b1; redirect_pc = 8'h80;
        at_neg();
        chk("hs_out_valid", {7'b0, out_valid0}, 8'd1);
        chk("hs_out_pc", out_pc0, 8'h10);
        chk("hs_rom_en", {7'b0, rom_en0}, 8'd0);
        sb_restart0(8'h80);
        next();
        redirect_valid = 1'b0;
        at_neg();
        chk("hs_n1_out_valid", {7'b0, out_valid0}, 8'd0);
        chk("hs_n1_rom_addr", rom_addr0, 8'h80);
        next();
        step();
        at_neg();
        chk("hs_n3_out_valid", {7'b0, out_valid0}, 8'd1);
        chk("hs_n3_out_pc", out_pc0, 8'h80);
        next();
        for (int i = 0; i < 5; i++) step();

        chk("dut1_transfers", {7'b0, (n1 >= 5)}, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
